// File: rtl/cpu_muldiv_if.sv
// Issue-side bundle between the decode stage and the HI/LO unit.
// master drives the instruction; slave is the multiply/divide unit.
interface cpu_muldiv_if;
  logic        valid;
  logic [5:0]  ins;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output valid, ins, rs_data, rt_data,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  valid, ins, rs_data, rt_data,
    output stall, busy, done, hi, lo
  );
endinterface

// File: rtl/cpu_muldiv_ctrl.sv
// Iterative HI/LO unit: multu (shift-add), div/divu (restoring), 32 steps plus
// a sign-fix cycle. Owns HI/LO, services mthi/mtlo and interlocks issue.
module cpu_muldiv_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  cpu_muldiv_if.slave   bus
);

  localparam logic [5:0] INS_MFHI  = 6'd18;
  localparam logic [5:0] INS_MFLO  = 6'd19;
  localparam logic [5:0] INS_MTHI  = 6'd20;
  localparam logic [5:0] INS_MTLO  = 6'd21;
  localparam logic [5:0] INS_MULTU = 6'd26;
  localparam logic [5:0] INS_DIV   = 6'd27;
  localparam logic [5:0] INS_DIVU  = 6'd28;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
  typedef enum logic [1:0] {OP_MULTU, OP_DIV, OP_DIVU} op_t;

  state_t      state_reg;
  op_t         op_reg;
  logic [4:0]  cnt_reg;
  logic [31:0] a_reg;        // multiplicand / dividend magnitude (shifts left for divide)
  logic [31:0] b_reg;        // multiplier (shifts right) / divisor magnitude
  logic [31:0] rs_reg;
  logic [63:0] acc_reg;      // product, or {remainder, quotient}
  logic        q_neg_reg;
  logic        r_neg_reg;
  logic        div0_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  logic        is_arith;
  logic        touches_hilo;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [32:0] div_rem;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  assign is_arith     = (bus.ins == INS_MULTU) || (bus.ins == INS_DIV) || (bus.ins == INS_DIVU);
  assign touches_hilo = is_arith || (bus.ins == INS_MFHI) || (bus.ins == INS_MFLO) ||
                        (bus.ins == INS_MTHI) || (bus.ins == INS_MTLO);

  assign bus.stall = bus.valid && busy_reg && touches_hilo;
  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[63:32]} + (b_reg[0] ? {1'b0, a_reg} : 33'd0);
    div_shift = {acc_reg[63:32], a_reg[31]};
    div_ge    = (div_shift >= {1'b0, b_reg});
    div_rem   = div_ge ? (div_shift - {1'b0, b_reg}) : div_shift;
    fix_hi    = acc_reg[63:32];
    fix_lo    = acc_reg[31:0];
    // Divide by zero reports the original dividend, not its magnitude.
    if (op_reg != OP_MULTU && div0_reg) begin
      fix_hi = rs_reg;
      fix_lo = 32'hFFFF_FFFF;
    end else if (op_reg == OP_DIV) begin
      fix_hi = r_neg_reg ? -acc_reg[63:32] : acc_reg[63:32];
      fix_lo = q_neg_reg ? -acc_reg[31:0]  : acc_reg[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      op_reg    <= OP_MULTU;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      rs_reg    <= '0;
      acc_reg   <= '0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
      div0_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.valid && is_arith) begin
            op_reg    <= (bus.ins == INS_MULTU) ? OP_MULTU :
                         (bus.ins == INS_DIV)   ? OP_DIV   : OP_DIVU;
            a_reg     <= (bus.ins == INS_DIV && bus.rs_data[31]) ? -bus.rs_data : bus.rs_data;
            b_reg     <= (bus.ins == INS_DIV && bus.rt_data[31]) ? -bus.rt_data : bus.rt_data;
            rs_reg    <= bus.rs_data;
            q_neg_reg <= bus.rs_data[31] ^ bus.rt_data[31];
            r_neg_reg <= bus.rs_data[31];
            div0_reg  <= (bus.rt_data == 32'd0);
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= S_RUN;
          end else if (bus.valid && bus.ins == INS_MTHI) begin
            hi_reg <= bus.rs_data;
          end else if (bus.valid && bus.ins == INS_MTLO) begin
            lo_reg <= bus.rs_data;
          end
        end
        S_RUN: begin
          if (op_reg == OP_MULTU) begin
            acc_reg <= {mul_sum, acc_reg[31:1]};
            b_reg   <= b_reg >> 1;
          end else begin
            acc_reg <= {div_rem[31:0], acc_reg[30:0], div_ge};
            a_reg   <= a_reg << 1;
          end
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd31) state_reg <= S_FIX;
        end
        S_FIX: begin
          hi_reg    <= fix_hi;
          lo_reg    <= fix_lo;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
